line_bank_scheduler: RTL and testbench

Sequencing controller for the column-output stage of the bicubic upscaler. It owns every address, enable and bank-select signal of the line-buffer RAMs. Each accepted 96-bit input beat carries one column of four interpolated lines. The block writes that column into a bank of four line RAMs, then drains the bank line by line as an AXI4-Stream video output with SOF/EOL sideband. With ping-pong enabled, two banks let the writer fill one group while the reader drains the other.

---
 rtl/upscaler_pkg.sv | 14 +
 rtl/line_bank_out_cnt.sv | 72 +++++++
 rtl/line_bank_scheduler.sv | 133 +++++++++++++
 tb/tb_line_bank_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upscaler_pkg.sv
// Shared bicubic-upscaler constants and the line-bank read-state encoding.
package upscaler_pkg;

    localparam int unsigned H_OUT  = 1280;
    localparam int unsigned V_OUT  = 720;
    localparam int unsigned LINES  = 4;
    localparam int unsigned ADDR_W = 11;

    typedef enum logic {
        R_WAIT,
        R_RUN
    } rd_state_t;

endpackage

// File: rtl/line_bank_out_cnt.sv
// Output raster counters for the line-bank drain: tracks the pixel held in the
// output register and produces the SOF/EOL sideband plus the end-of-frame pulse.
module line_bank_out_cnt #(
    parameter int unsigned H_OUT = upscaler_pkg::H_OUT,
    parameter int unsigned V_OUT = upscaler_pkg::V_OUT
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic issue,
    input  logic m_valid,
    input  logic m_ready,
    output logic m_tuser,
    output logic m_tlast,
    output logic frame_done
);
    import upscaler_pkg::*;

    localparam int unsigned XW = (H_OUT > 1) ? $clog2(H_OUT) : 1;
    localparam int unsigned YW = (V_OUT > 1) ? $clog2(V_OUT) : 1;

    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          accept;
    logic          x_last;
    logic          y_last;

    assign accept = m_valid & m_ready;
    assign x_last = (out_x == XW'(H_OUT - 1));
    assign y_last = (out_y == YW'(V_OUT - 1));

    // out_x/out_y name the pixel in the output register (or the next one when
    // it is empty); an issue with m_valid high always coincides with its accept.
    always_comb begin
        pos_x = out_x;
        pos_y = out_y;
        if (m_valid) begin
            if (x_last) begin
                pos_x = '0;
                pos_y = y_last ? '0 : out_y + 1'b1;
            end else begin
                pos_x = out_x + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            out_x   <= '0;
            out_y   <= '0;
            m_tuser <= 1'b0;
            m_tlast <= 1'b0;
        end else begin
            if (accept) begin
                if (x_last) begin
                    out_x <= '0;
                    out_y <= y_last ? '0 : out_y + 1'b1;
                end else begin
                    out_x <= out_x + 1'b1;
                end
            end
            if (issue) begin
                m_tuser <= (pos_x == '0) && (pos_y == '0);
                m_tlast <= (pos_x == XW'(H_OUT - 1));
            end
        end
    end

    assign frame_done = accept & x_last & y_last;

endmodule

// File: rtl/line_bank_scheduler.sv
// Line-buffer bank sequencer: writes column beats into a bank of line RAMs and
// drains it line by line as AXI4-Stream. LINE_BANK_PINGPONG_EN enables two banks.
module line_bank_scheduler #(
    parameter int unsigned H_OUT  = upscaler_pkg::H_OUT,
    parameter int unsigned V_OUT  = upscaler_pkg::V_OUT,
    parameter int unsigned LINES  = upscaler_pkg::LINES,
    parameter int unsigned ADDR_W = upscaler_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [1:0]        rd_line,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              m_ready,
    output logic              m_valid,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic [1:0]        bank_full,
    output logic              frame_done
);
    import upscaler_pkg::*;

    rd_state_t  state_q;
    rd_state_t  state_d;
    logic       run;
    logic       issue;
    logic       wr_last;
    logic       rd_last;
    logic [1:0] full_set;
    logic [1:0] full_clr;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) run <= 1'b0;
        else         run <= 1'b1;
    end

    assign s_ready = run & ~bank_full[wr_bank];
    assign wr_en   = s_valid & s_ready;
    assign wr_last = wr_en & (wr_addr == ADDR_W'(H_OUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn)    wr_addr <= '0;
        else if (wr_en) wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
    end

    assign issue   = (state_q == R_RUN) & (~m_valid | m_ready);
    assign rd_en   = issue;
    assign rd_last = issue & (rd_line == 2'(LINES - 1)) & (rd_addr == ADDR_W'(H_OUT - 1));

`ifdef LINE_BANK_PINGPONG_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstn)      wr_bank <= 1'b0;
        else if (wr_last) wr_bank <= ~wr_bank;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)      rd_bank <= 1'b0;
        else if (rd_last) rd_bank <= ~rd_bank;
    end
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    // Fill and free may hit different banks in one cycle; both updates apply.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_last) full_set[wr_bank] = 1'b1;
        if (rd_last) full_clr[rd_bank] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) bank_full <= '0;
        else         bank_full <= (bank_full | full_set) & ~full_clr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= R_WAIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_WAIT:  if (bank_full[rd_bank]) state_d = R_RUN;
            R_RUN:   if (rd_last)            state_d = R_WAIT;
            default: state_d = R_WAIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_addr <= '0;
            rd_line <= '0;
        end else if (issue) begin
            if (rd_addr == ADDR_W'(H_OUT - 1)) begin
                rd_addr <= '0;
                rd_line <= (rd_line == 2'(LINES - 1)) ? '0 : rd_line + 1'b1;
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Output register tracks the RAM port-B data, one cycle behind rd_en.
    always_ff @(posedge i_clk) begin
        if (!i_rstn)      m_valid <= 1'b0;
        else if (issue)   m_valid <= 1'b1;
        else if (m_ready) m_valid <= 1'b0;
    end

    line_bank_out_cnt #(
        .H_OUT (H_OUT),
        .V_OUT (V_OUT)
    ) u_out_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .issue      (issue),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Directed bench for line_bank_scheduler (H_OUT=8, V_OUT=8, LINES=4) with a RAM
// model and a pixel scoreboard; adapts to LINE_BANK_PINGPONG_EN.
module tb_line_bank_scheduler;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned AW = 11;

    logic          clk;
    logic          rstn;
    logic          s_valid;
    logic          s_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          rd_bank;
    logic [1:0]    rd_line;
    logic [AW-1:0] rd_addr;
    logic          m_ready;
    logic          m_valid;
    logic          m_tuser;
    logic          m_tlast;
    logic [1:0]    bank_full;
    logic          frame_done;

    line_bank_scheduler #(
        .H_OUT  (H),
        .V_OUT  (V),
        .LINES  (L),
        .ADDR_W (AW)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_line    (rd_line),
        .rd_addr    (rd_addr),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .bank_full  (bank_full),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        u;
        logic        t;
        logic        f;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [2][4][8];
    logic [15:0] dout;

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned n_acc = 0, n_tl = 0, n_tu = 0, n_fd = 0, ov_cnt = 0;
    int unsigned w_cnt = 0, wr_budget = 0, mode = 1, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic cycle();
        logic acc;
        acc = s_valid & s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc && wr_budget > 0) wr_budget--;
        s_valid = (wr_budget > 0) && rstn;
        case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = (cyc % 3 == 0);
        endcase
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (!(wr_budget == 0 && q.size() == 0 && !m_valid && !rd_en && bank_full == 2'b00)) begin
            if (n == 600) begin
                fail(tag);
                return;
            end
            n++;
            cycle();
        end
    endtask

    // Monitor / RAM model / scoreboard, sampled on the inactive edge.
    logic        prv_rd_en = 1'b0, prv_mv = 1'b0, prv_mr = 1'b0, stall_prev = 1'b0;
    logic [15:0] hold_d;
    logic        hold_u, hold_t;

    always @(negedge clk) begin : mon
        exp_t        e;
        int unsigned x, g;
        if (!rstn) begin
            q.delete();
            w_cnt      = 0;
            prv_rd_en  = 1'b0;
            prv_mv     = 1'b0;
            prv_mr     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("mvalid_lat", m_valid, prv_rd_en | (prv_mv & ~prv_mr));
            if (stall_prev) begin
                chk("hold_data", dout, hold_d);
                chk("hold_tuser", m_tuser, hold_u);
                chk("hold_tlast", m_tlast, hold_t);
            end
            if (m_valid && m_ready) begin
                n_acc++;
                if (m_tlast) n_tl++;
                if (m_tuser) n_tu++;
                if (q.size() == 0) begin
                    fail("sb_underflow");
                end else begin
                    e = q.pop_front();
                    chk("pix_data", dout, e.d);
                    chk("pix_tuser", m_tuser, e.u);
                    chk("pix_tlast", m_tlast, e.t);
                    chk("pix_fdone", frame_done, e.f);
                end
            end else begin
                chk("fdone_idle", frame_done, 1'b0);
            end
            if (frame_done) n_fd++;
            if (wr_en) begin
                x = w_cnt % H;
                g = w_cnt / H;
                chk("wr_addr", wr_addr, x);
`ifdef LINE_BANK_PINGPONG_EN
                chk("wr_bank", wr_bank, g % 2);
                if (bank_full[~wr_bank]) ov_cnt++;
`else
                chk("wr_bank0_free", bank_full[0], 1'b0);
`endif
                for (int unsigned l = 0; l < L; l++)
                    mem[wr_bank][l][wr_addr[2:0]] = {g[7:0], l[3:0], x[3:0]};
                if (x == H - 1) begin
                    for (int unsigned l = 0; l < L; l++)
                        for (int unsigned px = 0; px < H; px++) begin
                            e.d = {g[7:0], l[3:0], px[3:0]};
                            e.u = (g % 2 == 0) && (l == 0) && (px == 0);
                            e.t = (px == H - 1);
                            e.f = (g % 2 == 1) && (l == L - 1) && (px == H - 1);
                            q.push_back(e);
                        end
                end
                w_cnt++;
            end
            if (rd_en) dout = (rd_addr < H) ? mem[rd_bank][rd_line][rd_addr[2:0]] : 16'hxxxx;
            stall_prev = m_valid & ~m_ready;
            hold_d     = dout;
            hold_u     = m_tuser;
            hold_t     = m_tlast;
            prv_rd_en  = rd_en;
            prv_mv     = m_valid;
            prv_mr     = m_ready;
        end
    end

    initial begin
        int unsigned a0, t0, u0, f0, n;
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        dout    = '0;
        repeat (3) cycle();
        chk("reset_outputs",
            {s_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_line, rd_addr,
             m_valid, m_tuser, m_tlast, bank_full, frame_done}, 64'd0);

        // Reset release with s_valid high, then first-group latency.
        rstn      = 1'b1;
        wr_budget = 8;
        s_valid   = 1'b1;
        chk("s_ready_cyc0", s_ready, 1'b0);
        cycle();
        chk("s_ready_cyc1", s_ready, 1'b1);
        n = 0;
        while (wr_budget > 0 && n < 30) begin
            cycle();
            n++;
        end
        chk("bank_full_n1", bank_full, 2'b01);
        chk("rd_en_n1", rd_en, 1'b0);
        cycle();
        chk("rd_en_n2", rd_en, 1'b1);
        chk("m_valid_n2", m_valid, 1'b0);
        cycle();
        chk("m_valid_n3", m_valid, 1'b1);
        wr_budget = 8;
        wait_drain("drain_first_frame");

        // Continuous input, one full frame.
        a0 = n_acc; t0 = n_tl; u0 = n_tu; f0 = n_fd;
        wr_budget = 16;
        wait_drain("drain_continuous");
        chk("cont_pixels", n_acc - a0, 64);
        chk("cont_tlast", n_tl - t0, 8);
        chk("cont_tuser", n_tu - u0, 1);
        chk("cont_fdone", n_fd - f0, 1);
`ifdef LINE_BANK_PINGPONG_EN
        chk("pp_overlap", ov_cnt != 0, 1'b1);
`endif

        // Backpressure, 1 ready in 3 cycles.
        mode = 2;
        a0 = n_acc; f0 = n_fd;
        wr_budget = 16;
        wait_drain("drain_stall");
        chk("stall_pixels", n_acc - a0, 64);
        chk("stall_fdone", n_fd - f0, 1);

        // All banks full with m_ready low, then release.
        mode = 0;
        wr_budget = 16;
        repeat (40) cycle();
        chk("full_s_ready", s_ready, 1'b0);
`ifdef LINE_BANK_PINGPONG_EN
        chk("full_banks", bank_full, 2'b11);
`else
        chk("full_banks", bank_full, 2'b01);
`endif
        mode = 1;
        a0 = n_acc;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_ready && n < 100);
        chk("free_after_accepts", n_acc - a0, 31);
        wait_drain("drain_full");

        // Reset in the middle of a drain.
        wr_budget = 8;
        n = 0;
        while (rd_line != 2'd2 && n < 200) begin
            cycle();
            n++;
        end
        chk("reach_rd_line2", rd_line, 2'd2);
        rstn      = 1'b0;
        wr_budget = 0;
        s_valid   = 1'b0;
        cycle();
        chk("midreset_outputs",
            {s_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_line, rd_addr,
             m_valid, m_tuser, m_tlast, bank_full, frame_done}, 64'd0);
        cycle();
        rstn = 1'b1;
        a0 = n_acc; u0 = n_tu; f0 = n_fd;
        wr_budget = 16;
        wait_drain("drain_after_reset");
        chk("rst_pixels", n_acc - a0, 64);
        chk("rst_tuser", n_tu - u0, 1);
        chk("rst_fdone", n_fd - f0, 1);

        repeat (3) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
